// File: rtl/vending_if.sv
// Coin, selection and payout signals of the vending controller.
// master drives coins and selections; slave is the controller.
interface vending_if #(
    parameter int SEL_W    = 2,
    parameter int NPROD    = 3,
    parameter int CREDIT_W = 7
);
    logic                credit5;
    logic                credit10;
    logic                cancel;
    logic [SEL_W-1:0]    sel;
    logic [NPROD-1:0]    vend;
    logic                change5;
    logic                change10;
    logic                coin_reject;
    logic                deny;
    logic [CREDIT_W-1:0] credit;
    logic [1:0]          current_state;

    modport master (
        output credit5, credit10, cancel, sel,
        input  vend, change5, change10, coin_reject,
        input  deny, credit, current_state
    );

    modport slave (
        input  credit5, credit10, cancel, sel,
        output vend, change5, change10, coin_reject,
        output deny, credit, current_state
    );
endinterface

// File: rtl/vending_fsm.sv
// Vending controller: collects 5/10 coins, vends priced products and
// pays change back greedily in 10s then 5s.
module vending_fsm #(
    parameter int                        NPROD      = 3,
    parameter int                        SEL_W      = 2,
    parameter int                        CREDIT_W   = 7,
    parameter int                        MAX_CREDIT = 95,
    parameter logic [NPROD*CREDIT_W-1:0] PRICES     = {7'd30, 7'd25, 7'd20}
) (
    input logic       clk,
    input logic       rst_n,
    vending_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CREDIT = 2'd1,
        VEND   = 2'd2,
        CHANGE = 2'd3
    } state_t;

    localparam int W1 = CREDIT_W + 1;

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic [SEL_W-1:0]    prod_q;
    logic                deny_q;
    logic                reject_q;

    logic [W1-1:0]       coin_v;
    logic [W1-1:0]       sum;
    logic [CREDIT_W-1:0] price;
    logic                coin_in;
    logic                sel_ok;
    logic                afford;
    logic                fits;
    logic [NPROD-1:0]    vend_d;

    always_comb begin
        coin_v = '0;
        if (bus.credit5)
            coin_v = coin_v + W1'(5);
        if (bus.credit10)
            coin_v = coin_v + W1'(10);
        coin_in = bus.credit5 | bus.credit10;
        // one extra bit so an overflowing sum is still seen as too large
        sum  = {1'b0, credit_q} + coin_v;
        fits = (sum <= W1'(MAX_CREDIT));
        price  = '0;
        sel_ok = 1'b0;
        for (int k = 1; k <= NPROD; k++) begin
            if (int'(bus.sel) == k) begin
                sel_ok = 1'b1;
                price  = PRICES[(k-1)*CREDIT_W +: CREDIT_W];
            end
        end
        afford = sel_ok && (credit_q >= price);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            credit_q <= '0;
            prod_q   <= '0;
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
        end else begin
            deny_q   <= 1'b0;
            reject_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    deny_q <= (bus.sel != '0);
                    if (coin_in) begin
                        credit_q <= coin_v[CREDIT_W-1:0];
                        state    <= CREDIT;
                    end
                end
                CREDIT: begin
                    if (bus.cancel) begin
                        reject_q <= coin_in;
                        state    <= CHANGE;
                    end else if (afford) begin
                        reject_q <= coin_in;
                        credit_q <= credit_q - price;
                        prod_q   <= bus.sel;
                        state    <= VEND;
                    end else begin
                        deny_q <= (bus.sel != '0);
                        if (coin_in) begin
                            if (fits)
                                credit_q <= sum[CREDIT_W-1:0];
                            else
                                reject_q <= 1'b1;
                        end
                    end
                end
                VEND: begin
                    reject_q <= coin_in;
                    state    <= (credit_q != '0) ? CHANGE : IDLE;
                end
                CHANGE: begin
                    reject_q <= coin_in;
                    if (credit_q >= CREDIT_W'(10))
                        credit_q <= credit_q - CREDIT_W'(10);
                    else if (credit_q >= CREDIT_W'(5))
                        credit_q <= credit_q - CREDIT_W'(5);
                    else
                        credit_q <= '0;
                    if (credit_q == CREDIT_W'(10) ||
                        credit_q <= CREDIT_W'(5))
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        vend_d = '0;
        for (int k = 1; k <= NPROD; k++) begin
            if (state == VEND && int'(prod_q) == k)
                vend_d[k-1] = 1'b1;
        end
    end

    assign bus.vend          = vend_d;
    assign bus.change10      = (state == CHANGE) &&
                               (credit_q >= CREDIT_W'(10));
    assign bus.change5       = (state == CHANGE) &&
                               (credit_q < CREDIT_W'(10)) &&
                               (credit_q != '0);
    assign bus.coin_reject   = reject_q;
    assign bus.deny          = deny_q;
    assign bus.credit        = credit_q;
    assign bus.current_state = state;
endmodule

// File: tb/tb_vending_fsm.sv
// Bench for vending_fsm: random and directed stimulus against a
// transaction-level model, with a queue-based payout/flag scoreboard.
module tb_vending_fsm;
    localparam int NPROD    = 3;
    localparam int SEL_W    = 2;
    localparam int CREDIT_W = 7;
    localparam int MAXC     = 95;
    localparam int PW       = NPROD + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vending_if #(.SEL_W(SEL_W), .NPROD(NPROD), .CREDIT_W(CREDIT_W)) bus ();

    vending_fsm #(
        .NPROD(NPROD), .SEL_W(SEL_W), .CREDIT_W(CREDIT_W),
        .MAX_CREDIT(MAXC), .PRICES({7'd30, 7'd25, 7'd20})
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    // payout word is {vend, change10, change5}; flag word is {deny, reject}
    logic [PW-1:0] pay_q[$];
    logic [1:0]    flag_q[$];

    int price[4] = '{0, 20, 25, 30};
    int cr = 0;
    bit collecting = 0;
    int busy = 0;
    bit exp_valid = 0;
    int exp_cr = 0;
    int exp_st = 0;
    bit started = 0;

    task automatic check(string name, int act, int req);
        n_chk++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)",
                     name, act, req, $time);
        end
    endtask

    function automatic void push_change(int c);
        while (c >= 10) begin
            pay_q.push_back(PW'(2));
            c -= 10;
            busy++;
        end
        if (c == 5) begin
            pay_q.push_back(PW'(1));
            busy++;
        end
    endfunction

    task automatic step(bit c5, bit c10, int s, bit cn, bit rst);
        int v;
        bit dn;
        bit rj;
        bit occ;
        @(negedge clk);
        bus.credit5  = c5;
        bus.credit10 = c10;
        bus.sel      = SEL_W'(s);
        bus.cancel   = cn;
        rst_n        = !rst;
        v   = 5 * int'(c5) + 10 * int'(c10);
        dn  = 0;
        rj  = 0;
        occ = (busy > 0);
        if (occ)
            busy--;
        if (rst) begin
            repeat (busy) void'(pay_q.pop_back());
            busy = 0;
            cr = 0;
            collecting = 0;
        end else if (occ) begin
            rj = (v > 0);
        end else if (!collecting) begin
            dn = (s != 0);
            if (v > 0) begin
                cr = v;
                collecting = 1;
            end
        end else if (cn) begin
            rj = (v > 0);
            push_change(cr);
            cr = 0;
            collecting = 0;
        end else if (s >= 1 && s <= NPROD && cr >= price[s]) begin
            rj = (v > 0);
            pay_q.push_back(PW'(1 << (s + 1)));
            busy++;
            push_change(cr - price[s]);
            cr = 0;
            collecting = 0;
        end else begin
            dn = (s != 0);
            if (v > 0) begin
                if (cr + v <= MAXC)
                    cr += v;
                else
                    rj = 1;
            end
        end
        if (dn || rj)
            flag_q.push_back({dn, rj});
        exp_valid = (busy == 0);
        exp_cr    = cr;
        exp_st    = collecting ? 1 : 0;
        started   = 1;
    endtask

    task automatic idle(int n);
        repeat (n) step(0, 0, 0, 0, 0);
    endtask

    initial begin
        logic [PW-1:0] p;
        logic [1:0]    f;
        forever begin
            @(posedge clk);
            #1;
            if (started) begin
                p = {bus.vend, bus.change10, bus.change5};
                f = {bus.deny, bus.coin_reject};
                check("payout_onehot", int'($countones(p) <= 1), 1);
                if (p != '0) begin
                    if (pay_q.size() == 0)
                        check("payout_unexpected", int'(p), 0);
                    else
                        check("payout", int'(p), int'(pay_q.pop_front()));
                end
                if (f != '0) begin
                    if (flag_q.size() == 0)
                        check("flag_unexpected", int'(f), 0);
                    else
                        check("deny_reject", int'(f), int'(flag_q.pop_front()));
                end
                if (exp_valid) begin
                    check("credit", int'(bus.credit), exp_cr);
                    check("state", int'(bus.current_state), exp_st);
                end
            end
        end
    end

    initial begin
        step(0, 0, 0, 0, 1);
        step(1, 1, 3, 1, 1);
        idle(2);
        // 10,10,5 then product 2 at exactly 25
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 2, 0, 0);
        idle(3);
        // 30 credit, product 1, one change10
        repeat (3) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(4);
        // both coins together then cancel
        step(1, 1, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(4);
        // fill to 90, overflowing coin, then top up to 95
        repeat (9) step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        idle(12);
        // insufficient selection with a coin in the same cycle
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 3, 0, 0);
        step(0, 0, 3, 1, 0);
        idle(4);
        // reset in the second change cycle of a 25 refund
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 2, 0, 0);
        step(0, 0, 0, 0, 1);
        idle(3);
        // sel in IDLE is denied, cancel ignored, coin during VEND rejected
        step(0, 0, 1, 1, 0);
        repeat (2) step(0, 1, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 1, 0, 0, 0);
        idle(3);
        for (int i = 0; i < 4000; i++) begin
            step($urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) == 0,
                 ($urandom_range(0, 4) == 0) ? $urandom_range(0, 3) : 0,
                 $urandom_range(0, 24) == 0,
                 $urandom_range(0, 199) == 0);
        end
        for (int i = 0; i < 30 && busy > 0; i++)
            idle(1);
        idle(2);
        @(posedge clk);
        #2;
        check("payout_queue_empty", pay_q.size(), 0);
        check("flag_queue_empty", flag_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/vending_fsm.md
VENDING_FSM -- requirements
Module: vending_fsm

Interface
REQ-001 Parameter NPROD, default 3: number of products; select codes 1..NPROD are valid, code 0 means no selection.
REQ-002 Parameter SEL_W, default 2: width of sel; 2^SEL_W SHALL be greater than NPROD.
REQ-003 Parameter CREDIT_W, default 7: width of the credit register and of each price field.
REQ-004 Parameter MAX_CREDIT, default 95: highest credit value accepted; it SHALL be a multiple of 5.
REQ-005 Parameter PRICES, default {7'd30,7'd25,7'd20}: packed NPROD*CREDIT_W prices; field k-1 holds the price of product k; every price SHALL be a nonzero multiple of 5.
REQ-006 clk  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_n  input  1  synchronous, active-low reset.
REQ-008 credit5  input  1  one-cycle pulse: 5-unit coin inserted.
REQ-009 credit10  input  1  one-cycle pulse: 10-unit coin inserted.
REQ-010 sel  input  SEL_W  product selection, sampled every cycle.
REQ-011 cancel  input  1  one-cycle pulse: refund the current credit.
REQ-012 vend  output  NPROD  one-hot dispense strobe; bit k-1 dispenses product k.
REQ-013 change5 / change10  output  1 each  one coin of change per cycle.
REQ-014 coin_reject  output  1  registered pulse: a coin was returned unaccepted.
REQ-015 deny  output  1  registered pulse: a selection was refused.
REQ-016 credit  output  CREDIT_W  current credit register.
REQ-017 current_state  output  2  state register: IDLE=0, CREDIT=1, VEND=2, CHANGE=3.

Function
REQ-018 Coin value per cycle SHALL be 5*credit5 + 10*credit10; both coins asserted together SHALL add 15.
REQ-019 IDLE: a nonzero coin value v SHALL set credit to v and move to CREDIT on the next edge; cancel SHALL be ignored; sel!=0 SHALL pulse deny.
REQ-020 CREDIT priority SHALL be cancel, then valid selection, then coin.
REQ-021 CREDIT, cancel=1: the next state SHALL be CHANGE with credit unchanged; any coin in that cycle SHALL be rejected.
REQ-022 CREDIT, sel=k with 1<=k<=NPROD and credit>=price_k: credit SHALL become credit-price_k, k SHALL be latched, and the next state SHALL be VEND; any coin in that cycle SHALL be rejected.
REQ-023 CREDIT, sel>NPROD or credit<price_sel: deny SHALL pulse, the state SHALL be held, and a coin in that cycle SHALL still be processed.
REQ-024 Coin processing: if credit+v<=MAX_CREDIT, credit SHALL become credit+v; otherwise credit SHALL be unchanged and coin_reject SHALL pulse; the sum SHALL be computed at CREDIT_W+1 bits.
REQ-025 VEND lasts exactly one cycle: vend[k-1]=1; the next state SHALL be CHANGE if credit>0, else IDLE.
REQ-026 CHANGE, per cycle: if credit>=10 then change10=1 and credit-=10; else change5=1 and credit-=5.
REQ-027 CHANGE: the state SHALL return to IDLE on the edge where credit reaches 0.
REQ-028 CHANGE: coins SHALL be rejected, and sel and cancel SHALL be ignored.
REQ-029 Coins in VEND SHALL be rejected.
REQ-030 vend, change5 and change10 SHALL be decoded from registered state and credit only, so they are glitch-free Moore outputs.
REQ-031 deny and coin_reject SHALL be registered and SHALL appear the cycle after the causing input.
REQ-032 At most one of vend, change5 or change10 SHALL be nonzero in any cycle.
REQ-033 Latency: a selection accepted at edge N SHALL give vend in cycle N+1 and the first change coin in cycle N+2.
REQ-034 Credit SHALL never exceed MAX_CREDIT and SHALL never wrap below 0.

Reset
REQ-035 rst_n=0 at a rising edge SHALL force state IDLE, credit 0, latched product 0, and deny=coin_reject=0.
REQ-036 With state IDLE and credit 0, vend, change5 and change10 SHALL all be 0.
REQ-037 Reset SHALL take priority over every input in every state, including mid-VEND and mid-CHANGE; credit is discarded, not refunded.
REQ-038 Asserting rst_n low between edges SHALL have no effect until the next edge.

Verification
REQ-039 Coin sequence 10, 10, 5, then sel=2 -> credit 25, then 0; vend=3'b010 for one cycle; no change coins; back to IDLE.
REQ-040 Credit 30, sel=1 (price 20) -> vend=3'b001, then change10 for one cycle; credit 0; IDLE.
REQ-041 credit5 and credit10 asserted in the same cycle from IDLE -> credit 15; then cancel -> change10, change5 on consecutive cycles; IDLE.
REQ-042 Credit 90, then credit10 -> coin_reject on the next cycle; credit stays 90; a following credit5 -> credit 95.
REQ-043 Credit 15 and sel=3 -> deny the next cycle; state CREDIT, credit 15; a credit5 in the same cycle as sel=3 -> credit 20.
REQ-044 rst_n low during the second CHANGE cycle of a 25-unit refund -> next cycle IDLE, credit 0, all outputs 0.
